// File: rtl/computer_move_engine.sv
// computer_move_engine: picks the computer's next tic-tac-toe cell from a
// snapshot of the board. The search order is winning line, then blocking
// line, then a fixed preference order. One line or slot is examined per cycle.
module computer_move_engine #(
  parameter logic [1:0]  COM_CODE      = 2'b10,
  parameter logic [1:0]  PLY_CODE      = 2'b01,
  parameter int unsigned PREFER_CENTER = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] p1,
  input  logic [1:0] p2,
  input  logic [1:0] p3,
  input  logic [1:0] p4,
  input  logic [1:0] p5,
  input  logic [1:0] p6,
  input  logic [1:0] p7,
  input  logic [1:0] p8,
  input  logic [1:0] p9,
  output logic [3:0] com_position,
  output logic       pc,
  output logic       no_move,
  output logic       busy
);

  localparam int unsigned NUM_CELLS = 9;
  localparam int unsigned CELL_W    = 4;
  localparam int unsigned LINE_W    = 3;
  localparam int unsigned SLOT_W    = 4;

  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(7);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(8);
  localparam logic [1:0]        EMPTY     = 2'b00;

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] SCAN_WIN    = 2'd1;
  localparam logic [1:0] SCAN_BLOCK  = 2'd2;
  localparam logic [1:0] SCAN_STATIC = 2'd3;

  // Registered state
  logic [1:0]                 state;
  logic [LINE_W-1:0]          line_idx;
  logic [SLOT_W-1:0]          slot_idx;
  logic [NUM_CELLS-1:0][1:0]  snap;

  // Next-state values
  logic [1:0]                 state_nxt;
  logic [LINE_W-1:0]          line_idx_nxt;
  logic [SLOT_W-1:0]          slot_idx_nxt;
  logic [NUM_CELLS-1:0][1:0]  snap_nxt;
  logic [CELL_W-1:0]          com_position_nxt;
  logic                       pc_nxt;
  logic                       no_move_nxt;
  logic                       busy_nxt;

  // Line evaluation signals
  logic [3*CELL_W-1:0]        line_cells_c;
  logic [CELL_W-1:0]          cell_a_c;
  logic [CELL_W-1:0]          cell_b_c;
  logic [CELL_W-1:0]          cell_c_c;
  logic [1:0]                 scan_code_c;
  logic [CELL_W:0]            line_result_c;
  logic                       line_hit_c;
  logic [CELL_W-1:0]          line_cell_c;

  // Static preference signals
  logic [CELL_W-1:0]          static_cell_c;
  logic                       static_free_c;

  // Cell indices of the three cells making up line idx
  function automatic logic [3*CELL_W-1:0] line_cells(input logic [LINE_W-1:0] idx);
    case (idx)
      LINE_W'(0): line_cells = {CELL_W'(0), CELL_W'(1), CELL_W'(2)};
      LINE_W'(1): line_cells = {CELL_W'(3), CELL_W'(4), CELL_W'(5)};
      LINE_W'(2): line_cells = {CELL_W'(6), CELL_W'(7), CELL_W'(8)};
      LINE_W'(3): line_cells = {CELL_W'(0), CELL_W'(3), CELL_W'(6)};
      LINE_W'(4): line_cells = {CELL_W'(1), CELL_W'(4), CELL_W'(7)};
      LINE_W'(5): line_cells = {CELL_W'(2), CELL_W'(5), CELL_W'(8)};
      LINE_W'(6): line_cells = {CELL_W'(0), CELL_W'(4), CELL_W'(8)};
      default:    line_cells = {CELL_W'(2), CELL_W'(4), CELL_W'(6)};
    endcase
  endfunction

  // Hit when exactly two cells hold code and the third is empty; a cell
  // holding 11 matches neither, so such a line can never hit
  function automatic logic [CELL_W:0] line_hit(
    input logic [1:0]        va,
    input logic [1:0]        vb,
    input logic [1:0]        vc,
    input logic [CELL_W-1:0] ca,
    input logic [CELL_W-1:0] cb,
    input logic [CELL_W-1:0] cc,
    input logic [1:0]        code
  );
    line_hit = '0;
    if (va == code && vb == code && vc == EMPTY) begin
      line_hit = {1'b1, cc};
    end else if (va == code && vc == code && vb == EMPTY) begin
      line_hit = {1'b1, cb};
    end else if (vb == code && vc == code && va == EMPTY) begin
      line_hit = {1'b1, ca};
    end
  endfunction

  // Static preference order: centre first or corners first
  function automatic logic [CELL_W-1:0] static_cell(input logic [SLOT_W-1:0] slot);
    static_cell = '0;
    if (PREFER_CENTER != 0) begin
      case (slot)
        SLOT_W'(0): static_cell = CELL_W'(4);
        SLOT_W'(1): static_cell = CELL_W'(0);
        SLOT_W'(2): static_cell = CELL_W'(2);
        SLOT_W'(3): static_cell = CELL_W'(6);
        SLOT_W'(4): static_cell = CELL_W'(8);
        SLOT_W'(5): static_cell = CELL_W'(1);
        SLOT_W'(6): static_cell = CELL_W'(3);
        SLOT_W'(7): static_cell = CELL_W'(5);
        default:    static_cell = CELL_W'(7);
      endcase
    end else begin
      case (slot)
        SLOT_W'(0): static_cell = CELL_W'(0);
        SLOT_W'(1): static_cell = CELL_W'(2);
        SLOT_W'(2): static_cell = CELL_W'(6);
        SLOT_W'(3): static_cell = CELL_W'(8);
        SLOT_W'(4): static_cell = CELL_W'(4);
        SLOT_W'(5): static_cell = CELL_W'(1);
        SLOT_W'(6): static_cell = CELL_W'(3);
        SLOT_W'(7): static_cell = CELL_W'(5);
        default:    static_cell = CELL_W'(7);
      endcase
    end
  endfunction

  // Evaluate the current line and static slot against the snapshot
  always_comb begin
    line_cells_c  = line_cells(line_idx);
    cell_a_c      = line_cells_c[3*CELL_W-1:2*CELL_W];
    cell_b_c      = line_cells_c[2*CELL_W-1:CELL_W];
    cell_c_c      = line_cells_c[CELL_W-1:0];
    scan_code_c   = (state == SCAN_BLOCK) ? PLY_CODE : COM_CODE;
    line_result_c = line_hit(snap[cell_a_c], snap[cell_b_c], snap[cell_c_c],
                             cell_a_c, cell_b_c, cell_c_c, scan_code_c);
    line_hit_c    = line_result_c[CELL_W];
    line_cell_c   = line_result_c[CELL_W-1:0];
    static_cell_c = static_cell(slot_idx);
    static_free_c = (snap[static_cell_c] == EMPTY);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt        = state;
    line_idx_nxt     = line_idx;
    slot_idx_nxt     = slot_idx;
    snap_nxt         = snap;
    com_position_nxt = com_position;
    pc_nxt           = 1'b0;
    no_move_nxt      = 1'b0;
    busy_nxt         = busy;

    case (state)
      IDLE: begin
        if (start) begin
          snap_nxt     = {p9, p8, p7, p6, p5, p4, p3, p2, p1};
          busy_nxt     = 1'b1;
          line_idx_nxt = '0;
          state_nxt    = SCAN_WIN;
        end
      end

      SCAN_WIN, SCAN_BLOCK: begin
        if (line_hit_c) begin
          com_position_nxt = line_cell_c;
          pc_nxt           = 1'b1;
          busy_nxt         = 1'b0;
          state_nxt        = IDLE;
        end else if (line_idx == LAST_LINE) begin
          line_idx_nxt = '0;
          if (state == SCAN_WIN) begin
            state_nxt = SCAN_BLOCK;
          end else begin
            slot_idx_nxt = '0;
            state_nxt    = SCAN_STATIC;
          end
        end else begin
          line_idx_nxt = line_idx + LINE_W'(1);
        end
      end

      SCAN_STATIC: begin
        if (static_free_c) begin
          com_position_nxt = static_cell_c;
          pc_nxt           = 1'b1;
          busy_nxt         = 1'b0;
          state_nxt        = IDLE;
        end else if (slot_idx == LAST_SLOT) begin
          no_move_nxt = 1'b1;
          busy_nxt    = 1'b0;
          state_nxt   = IDLE;
        end else begin
          slot_idx_nxt = slot_idx + SLOT_W'(1);
        end
      end

      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      line_idx     <= '0;
      slot_idx     <= '0;
      snap         <= '0;
      com_position <= '0;
      pc           <= 1'b0;
      no_move      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      line_idx     <= line_idx_nxt;
      slot_idx     <= slot_idx_nxt;
      snap         <= snap_nxt;
      com_position <= com_position_nxt;
      pc           <= pc_nxt;
      no_move      <= no_move_nxt;
      busy         <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_computer_move_engine.sv
// Directed bench for computer_move_engine: two instances (centre-first and
// corner-first) share one board; expected outcomes go through a queue.
module tb_computer_move_engine;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [17:0] board;

  logic [3:0] com_position_a, com_position_b;
  logic       pc_a, pc_b, no_move_a, no_move_b, busy_a, busy_b;

  typedef struct {
    logic       is_move;
    logic [3:0] pos_a;
    logic [3:0] pos_b;
    int         lat_a;
    int         lat_b;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  computer_move_engine #(.COM_CODE(2'b10), .PLY_CODE(2'b01), .PREFER_CENTER(1)) dut_a (
    .clock(clock), .reset(reset), .start(start),
    .p1(board[1:0]), .p2(board[3:2]), .p3(board[5:4]), .p4(board[7:6]), .p5(board[9:8]),
    .p6(board[11:10]), .p7(board[13:12]), .p8(board[15:14]), .p9(board[17:16]),
    .com_position(com_position_a), .pc(pc_a), .no_move(no_move_a), .busy(busy_a)
  );

  computer_move_engine #(.COM_CODE(2'b10), .PLY_CODE(2'b01), .PREFER_CENTER(0)) dut_b (
    .clock(clock), .reset(reset), .start(start),
    .p1(board[1:0]), .p2(board[3:2]), .p3(board[5:4]), .p4(board[7:6]), .p5(board[9:8]),
    .p6(board[11:10]), .p7(board[13:12]), .p8(board[15:14]), .p9(board[17:16]),
    .com_position(com_position_b), .pc(pc_b), .no_move(no_move_b), .busy(busy_b)
  );

  function automatic logic [17:0] mk(input logic [1:0] c0, input logic [1:0] c1,
                                     input logic [1:0] c2, input logic [1:0] c3,
                                     input logic [1:0] c4, input logic [1:0] c5,
                                     input logic [1:0] c6, input logic [1:0] c7,
                                     input logic [1:0] c8);
    return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one request (or continue from a start already held), queue the
  // expectation, wait for both strobes, then pop and compare.
  task automatic run_search(input string tag, input logic [17:0] b, input logic is_move,
                            input logic [3:0] pa, input logic [3:0] pb,
                            input int la, input int lb, input logic hold,
                            input logic chained, input int chg_cyc,
                            input logic [17:0] chg_b);
    exp_t       e;
    exp_t       got;
    int         lat_oa = -1;
    int         lat_ob = -1;
    logic       kind_a = 1'b0;
    logic       kind_b = 1'b0;
    logic       both_a = 1'b0;
    logic       both_b = 1'b0;
    logic       bz_a = 1'b1;
    logic       bz_b = 1'b1;
    logic [3:0] pos_oa = 4'd0;
    logic [3:0] pos_ob = 4'd0;
    e.is_move = is_move;
    e.pos_a   = pa;
    e.pos_b   = pb;
    e.lat_a   = la;
    e.lat_b   = lb;
    if (!chained) begin
      @(negedge clock);
      board = b;
      start = 1'b1;
      @(posedge clock);
      #1;
    end
    sb.push_back(e);
    if (!hold) start = 1'b0;
    check({tag, "/busy_go"}, int'({busy_a, busy_b}), 3);
    for (int cyc = 1; cyc <= 40 && (lat_oa < 0 || lat_ob < 0); cyc++) begin
      @(posedge clock);
      #1;
      if (cyc == chg_cyc) board = chg_b;
      if (lat_oa < 0 && (pc_a || no_move_a)) begin
        lat_oa = cyc; kind_a = pc_a; both_a = pc_a & no_move_a;
        pos_oa = com_position_a; bz_a = busy_a;
      end
      if (lat_ob < 0 && (pc_b || no_move_b)) begin
        lat_ob = cyc; kind_b = pc_b; both_b = pc_b & no_move_b;
        pos_ob = com_position_b; bz_b = busy_b;
      end
    end
    got = sb.pop_front();
    check({tag, "/lat_a"}, lat_oa, got.lat_a);
    check({tag, "/lat_b"}, lat_ob, got.lat_b);
    check({tag, "/kind_a"}, int'(kind_a), int'(got.is_move));
    check({tag, "/kind_b"}, int'(kind_b), int'(got.is_move));
    check({tag, "/pos_a"}, int'(pos_oa), int'(got.pos_a));
    check({tag, "/pos_b"}, int'(pos_ob), int'(got.pos_b));
    check({tag, "/excl"}, int'({both_a, both_b}), 0);
    check({tag, "/busy_done"}, int'({bz_a, bz_b}), 0);
    @(posedge clock);
    #1;
    check({tag, "/strobe_off"}, int'({pc_a, pc_b, no_move_a, no_move_b}), 0);
    check({tag, "/busy_after"}, int'({busy_a, busy_b}), hold ? 3 : 0);
  endtask

  initial begin
    int strobes;
    reset = 1'b1;
    start = 1'b0;
    board = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst/pos", int'(com_position_a), 0);
    check("rst/strobes", int'({pc_a, no_move_a, pc_b, no_move_b}), 0);
    check("rst/busy", int'({busy_a, busy_b}), 0);
    @(negedge clock);
    reset = 1'b0;

    // Win on line 0 beats the block available on line 1
    run_search("win0", mk(2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00),
               1'b1, 4'd2, 4'd2, 1, 1, 1'b0, 1'b0, -1, '0);
    // No win; player threatens diagonal 0-4-8
    run_search("block6", mk(2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01),
               1'b1, 4'd0, 4'd0, 15, 15, 1'b0, 1'b0, -1, '0);
    // Static fallback where the two preference orders differ in slot
    run_search("static", mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00),
               1'b1, 4'd2, 4'd2, 19, 18, 1'b0, 1'b0, -1, '0);
    // Line 0 blocked by 11; line 4 is the lowest winning line (line 6 also wins)
    run_search("win4", mk(2'b10, 2'b10, 2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00),
               1'b1, 4'd7, 4'd7, 5, 5, 1'b0, 1'b0, -1, '0);
    // Full board: no_move, position keeps 7
    run_search("full", mk(2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10),
               1'b0, 4'd7, 4'd7, 25, 25, 1'b0, 1'b0, -1, '0);
    // Empty board
    run_search("empty", '0, 1'b1, 4'd4, 4'd0, 17, 17, 1'b0, 1'b0, -1, '0);

    // Reset in the middle of SCAN_BLOCK
    @(negedge clock);
    board = '0;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("midrst/pos", int'(com_position_a), 0);
    check("midrst/strobes", int'({pc_a, no_move_a, pc_b, no_move_b}), 0);
    check("midrst/busy", int'({busy_a, busy_b}), 0);
    @(negedge clock);
    reset = 1'b0;
    strobes = 0;
    repeat (30) begin
      @(posedge clock);
      #1;
      if (pc_a || pc_b || no_move_a || no_move_b) strobes++;
    end
    check("midrst/quiet", strobes, 0);
    run_search("fresh", '0, 1'b1, 4'd4, 4'd0, 17, 17, 1'b0, 1'b0, -1, '0);

    // start held high; p5 changes mid-search; second request taken in the pc cycle
    run_search("hold1", '0, 1'b1, 4'd4, 4'd0, 17, 17, 1'b1, 1'b0, 3,
               mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    run_search("hold2", '0, 1'b1, 4'd0, 4'd0, 18, 17, 1'b0, 1'b1, -1, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
